// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared types and constants for the MMIO bus controller: FSM states, slot map,
// default error read data and small helper functions.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam int DEV_MEM  = 0;
    localparam int DEV_FP   = 1;
    localparam int DEV_HEX  = 2;
    localparam int DEV_SW   = 3;
    localparam int DEV_LEDR = 4;
    localparam int DEV_KEY  = 5;

    // Wide all-ones constant; each user slices it down to its own data width.
    localparam logic [63:0] ERR_DATA_ALL = '1;

    // A zero timeout still needs a one-bit counter to keep the logic well formed.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// CPU-side request/response port of the MMIO bus controller. The CPU is the
// master; the controller is the slave.
interface mmio_bus_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              CpuRead;
    logic              CpuWrite;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWdata;
    logic [DATA_W-1:0] CpuRdata;
    logic              CpuDone;
    logic              CpuErr;

    modport master (
        output CpuRead, CpuWrite, CpuAddr, CpuWdata,
        input  CpuRdata, CpuDone, CpuErr
    );

    modport slave (
        input  CpuRead, CpuWrite, CpuAddr, CpuWdata,
        output CpuRdata, CpuDone, CpuErr
    );
endinterface

// File: rtl/mmio_bus_ctrl_watchdog.sv
// Per-access wait counter: counts stalled cycles and flags expiry when the count
// reaches TIMEOUT. It saturates instead of wrapping; TIMEOUT of 0 never expires.
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int              CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    assign expire = (TIMEOUT != 0) && (count == LIMIT);

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
    // block as the first branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: decodes the top address bits to a peripheral slot and runs
// each access through an IDLE/ACCESS/RESP handshake with timeout and error status.
module mmio_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEV_BITS = 4,
    parameter int                NUM_DEV  = 6,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_ALL[DATA_W-1:0]
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    mmio_bus_ctrl_if.slave               cpu,
    output logic [NUM_DEV-1:0]           DevSel,
    output logic                         DevRead,
    output logic                         DevWrite,
    output logic [ADDR_W-DEV_BITS-1:0]   DevAddr,
    output logic [DATA_W-1:0]            DevWdata,
    input  logic [NUM_DEV*DATA_W-1:0]    DevRdata,
    input  logic [NUM_DEV-1:0]           DevWaitreq,
    output logic [7:0]                   ErrCount,
    output logic [ADDR_W-1:0]            ErrAddr
);
    localparam int NUM_SLOT = 2 ** DEV_BITS;

    bus_state_t          state;
    logic                op_write;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DEV_BITS-1:0] idx_q;

    logic [DEV_BITS-1:0] req_idx;
    logic                req_valid;
    logic                decode_err;
    logic                expire;

    // Pad the per-slot inputs out to the full decode range so the latched index
    // can select them directly; unimplemented slots read as idle and zero.
    logic [NUM_SLOT-1:0] waitreq_ext;
    logic [DATA_W-1:0]   rdata_arr [NUM_SLOT];

    always_comb begin
        waitreq_ext                = '0;
        waitreq_ext[NUM_DEV-1:0]   = DevWaitreq;
        for (int i = 0; i < NUM_SLOT; i++) rdata_arr[i] = '0;
        for (int i = 0; i < NUM_DEV; i++)  rdata_arr[i] = DevRdata[i*DATA_W +: DATA_W];
    end

    assign req_idx    = cpu.CpuAddr[ADDR_W-1 -: DEV_BITS];
    assign req_valid  = cpu.CpuRead || cpu.CpuWrite;
    assign decode_err = int'(req_idx) >= NUM_DEV;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (Clock),
        .rst_n  (ResetN),
        .clear  (state == RESP),
        .enable ((state == ACCESS) && waitreq_ext[idx_q]),
        .expire (expire)
    );

    // NOTE: every state register uses non-blocking assignment so all of them
    // update together from the values seen at the same edge.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state    <= IDLE;
            op_write <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            idx_q    <= '0;
            ErrCount <= '0;
            ErrAddr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= cpu.CpuAddr;
                        wdata_q  <= cpu.CpuWdata;
                        op_write <= cpu.CpuWrite;
                        idx_q    <= req_idx;
                        if (decode_err) begin
                            err_q    <= 1'b1;
                            rdata_q  <= cpu.CpuWrite ? '0 : ERR_DATA;
                            ErrCount <= sat_inc(ErrCount);
                            ErrAddr  <= cpu.CpuAddr;
                            state    <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    // A slot that is ready wins over a coincident timeout.
                    if (!waitreq_ext[idx_q]) begin
                        rdata_q <= op_write ? '0 : rdata_arr[idx_q];
                        state   <= RESP;
                    end else if (expire) begin
                        err_q    <= 1'b1;
                        rdata_q  <= op_write ? '0 : ERR_DATA;
                        ErrCount <= sat_inc(ErrCount);
                        ErrAddr  <= addr_q;
                        state    <= RESP;
                    end
                end

                RESP: begin
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        DevSel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            DevSel[i] = (state == ACCESS) && (idx_q == DEV_BITS'(i));
        end
    end

    assign DevRead      = (state == ACCESS) && !op_write;
    assign DevWrite     = (state == ACCESS) && op_write;
    assign DevAddr      = addr_q[ADDR_W-DEV_BITS-1:0];
    assign DevWdata     = wdata_q;

    assign cpu.CpuDone  = (state == RESP);
    assign cpu.CpuErr   = (state == RESP) && err_q;
    assign cpu.CpuRdata = rdata_q;

endmodule
